// File: rtl/rf_pkg.sv
// Shared types and helpers for the bypassing register file with busy scoreboard.
package rf_pkg;

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} rf_state_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int ADDR_MAX   = 16;

   // True when an enabled write-back targets the address being looked up.
   function automatic logic addr_hit(input logic en,
                                     input logic [ADDR_MAX-1:0] a,
                                     input logic [ADDR_MAX-1:0] b);
      return en && (a == b);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: alloc sets, write-back clears, set wins on a tie.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic              alloc,
   input  logic [ADDR_W-1:0] alloc_a,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic              busy1,
   output logic              busy2
);

   localparam int N = 2 ** ADDR_W;

   logic [N-1:0] busy;
   logic [N-1:0] busy_nx;

   always_comb begin
      busy_nx = busy;
      if (en) begin
         if (we) begin
            busy_nx[wa] = 1'b0;
         end
         // Applied after the clear so back-to-back producers stay busy.
         if (alloc && !(ZERO_REG && alloc_a == '0)) begin
            busy_nx[alloc_a] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy <= '0;
      end else begin
         busy <= busy_nx;
      end
   end

   assign busy1 = en && busy[ra1] && !addr_hit(we, ADDR_MAX'(wa), ADDR_MAX'(ra1));
   assign busy2 = en && busy[ra2] && !addr_hit(we, ADDR_MAX'(wa), ADDR_MAX'(ra2));

endmodule

// File: rtl/rf_bypass_sb.sv
// Two-read/one-write register file with write-to-read bypass, busy scoreboard
// and a post-reset zeroing sweep that gates all traffic until it completes.
module rf_bypass_sb
   import rf_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic              busy1,
   output logic              busy2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              alloc,
   input  logic [ADDR_W-1:0] alloc_a,
   output logic              ready
);

   localparam int N = 2 ** ADDR_W;

   rf_state_e         state;
   rf_state_e         state_nx;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] clr_idx_nx;
   logic              run;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   logic [DATA_W-1:0] rf [N];

   assign run   = (state == RUN);
   assign ready = run;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nx;
         clr_idx <= clr_idx_nx;
      end
   end

   // The sweep owns the write port in CLEAR; clr_idx parks at N-1 afterwards.
   always_comb begin
      state_nx   = state;
      clr_idx_nx = clr_idx;
      mem_we     = 1'b0;
      mem_addr   = wa;
      mem_data   = wd;
      case (state)
         CLEAR: begin
            mem_we   = 1'b1;
            mem_addr = clr_idx;
            mem_data = '0;
            if (clr_idx == ADDR_W'(N - 1)) begin
               state_nx = RUN;
            end else begin
               clr_idx_nx = clr_idx + 1'b1;
            end
         end
         RUN: begin
            mem_we = we && !(ZERO_REG && wa == '0);
         end
         default: state_nx = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         rf[mem_addr] <= mem_data;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (run && !(ZERO_REG && ra1 == '0)) begin
         rd1 = addr_hit(we, ADDR_MAX'(wa), ADDR_MAX'(ra1)) ? wd : rf[ra1];
      end
      if (run && !(ZERO_REG && ra2 == '0)) begin
         rd2 = addr_hit(we, ADDR_MAX'(wa), ADDR_MAX'(ra2)) ? wd : rf[ra2];
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk     (clk),
      .rstn    (rstn),
      .en      (run),
      .we      (we),
      .wa      (wa),
      .alloc   (alloc),
      .alloc_a (alloc_a),
      .ra1     (ra1),
      .ra2     (ra2),
      .busy1   (busy1),
      .busy2   (busy2)
   );

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Bench for rf_bypass_sb: directed scenarios plus random traffic against an
// array-based model of the register file, busy table and clear sweep.
module tb_rf_bypass_sb;

   localparam int N   = 32;
   localparam int S_N = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic [4:0]  ra1, ra2, wa, alloc_a;
   logic [31:0] rd1, rd2, wd;
   logic        busy1, busy2, we, alloc, ready;

   logic [2:0]  s_ra1, s_ra2, s_wa, s_alloc_a;
   logic [15:0] s_rd1, s_rd2, s_wd;
   logic        s_busy1, s_busy2, s_we, s_alloc, s_ready;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_rf [N];
   logic        m_busy [N];
   logic        m_run;
   int          m_clr_left;
   int          s_edges;

   always #5 clk = ~clk;

   rf_bypass_sb dut (
      .clk(clk), .rstn(rstn), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd),
      .alloc(alloc), .alloc_a(alloc_a), .ready(ready)
   );

   rf_bypass_sb #(.DATA_W(16), .ADDR_W(3)) dut_s (
      .clk(clk), .rstn(rstn), .ra1(s_ra1), .ra2(s_ra2), .rd1(s_rd1), .rd2(s_rd2),
      .busy1(s_busy1), .busy2(s_busy2), .we(s_we), .wa(s_wa), .wd(s_wd),
      .alloc(s_alloc), .alloc_a(s_alloc_a), .ready(s_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (!m_run || a == 0) return 32'h0;
      if (we && wa == a) return wd;
      return m_rf[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (!m_run) return 1'b0;
      if (we && wa == a) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_reset();
      m_run      = 1'b0;
      m_clr_left = N;
      s_edges    = 0;
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic do_cycle();
      #1;
      check("rd1", rd1, exp_rd(ra1));
      check("rd2", rd2, exp_rd(ra2));
      check("busy1", 32'(busy1), 32'(exp_busy(ra1)));
      check("busy2", 32'(busy2), 32'(exp_busy(ra2)));
      check("ready", 32'(ready), 32'(m_run));
      check("s_ready", 32'(s_ready), 32'(s_edges >= S_N));
      @(posedge clk);
      if (rstn) begin
         s_edges++;
         if (!m_run) begin
            m_clr_left--;
            if (m_clr_left == 0) begin
               m_run = 1'b1;
               for (int i = 0; i < N; i++) m_rf[i] = 32'h0;
            end
         end else begin
            if (we && wa != 0) m_rf[wa] = wd;
            if (we) m_busy[wa] = 1'b0;
            if (alloc && alloc_a != 0) m_busy[alloc_a] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      we = 1'b0; alloc = 1'b0; wa = '0; wd = '0; alloc_a = '0;
   endtask

   initial begin
      rstn = 1'b0;
      ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; alloc = 1'b0; alloc_a = '0;
      s_ra1 = '0; s_ra2 = '0; s_wa = '0; s_wd = '0; s_we = 1'b0; s_alloc = 1'b0; s_alloc_a = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_rd1", rd1, 32'h0);
      check("reset_busy1", 32'(busy1), 32'h0);
      rstn = 1'b1;

      // Clear sweep: writes and allocs must be ignored for 32 cycles.
      ra1 = 5'd5; ra2 = 5'd5; we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
      alloc = 1'b1; alloc_a = 5'd5;
      for (int i = 0; i < N; i++) do_cycle();
      idle();
      #1;
      check("ready_cycle33", 32'(ready), 32'h1);
      check("rf5_after_clear", rd1, 32'h0);
      check("busy5_after_clear", 32'(busy1), 32'h0);
      do_cycle();

      // Bypass then array read of register 7.
      we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; ra1 = 5'd7;
      #1 check("bypass_rd1", rd1, 32'h1234_5678);
      do_cycle();
      idle();
      #1 check("array_rd1", rd1, 32'h1234_5678);
      do_cycle();

      // Register 0 stays zero and never busy.
      we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; alloc = 1'b1; alloc_a = 5'd0;
      #1 check("zero_bypass", rd1, 32'h0);
      do_cycle();
      idle();
      #1 check("zero_after", rd1, 32'h0);
      check("zero_busy", 32'(busy1), 32'h0);
      do_cycle();

      // Scoreboard on register 9.
      ra2 = 5'd9; alloc = 1'b1; alloc_a = 5'd9;
      do_cycle();
      idle();
      #1 check("busy9_set", 32'(busy2), 32'h1);
      do_cycle();
      we = 1'b1; wa = 5'd9; wd = $urandom;
      #1 check("busy9_fwd_clear", 32'(busy2), 32'h0);
      do_cycle();
      idle();
      #1 check("busy9_cleared", 32'(busy2), 32'h0);
      do_cycle();
      we = 1'b1; wa = 5'd9; wd = $urandom; alloc = 1'b1; alloc_a = 5'd9;
      do_cycle();
      idle();
      #1 check("busy9_set_wins", 32'(busy2), 32'h1);
      do_cycle();

      // Small instance: 8-entry file, top register.
      s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hA5A5; s_ra1 = 3'd7; s_ra2 = 3'd6;
      #1 check("s_bypass", 32'(s_rd1), 32'h0000_A5A5);
      do_cycle();
      s_we = 1'b0;
      #1 check("s_rf7", 32'(s_rd1), 32'h0000_A5A5);
      check("s_rf6", 32'(s_rd2), 32'h0);
      do_cycle();

      // Random traffic on a narrowed address range to force collisions.
      for (int i = 0; i < 400; i++) begin
         ra1 = 5'($urandom_range(0, 11));
         ra2 = 5'($urandom_range(0, 11));
         we = 1'($urandom_range(0, 1));
         wa = 5'($urandom_range(0, 11));
         wd = $urandom;
         alloc = 1'($urandom_range(0, 1));
         alloc_a = 5'($urandom_range(0, 11));
         do_cycle();
      end

      // Asynchronous reset mid-run.
      idle();
      we = 1'b1; wa = 5'd3; wd = 32'd5; alloc = 1'b1; alloc_a = 5'd4;
      do_cycle();
      idle();
      ra1 = 5'd3; ra2 = 5'd4;
      #1 check("pre_rst_rf3", rd1, 32'd5);
      check("pre_rst_busy4", 32'(busy2), 32'h1);
      #1 rstn = 1'b0;
      #1 check("rst_ready", 32'(ready), 32'h0);
      check("rst_busy4", 32'(busy2), 32'h0);
      check("rst_rd1", rd1, 32'h0);
      check("rst_s_ready", 32'(s_ready), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      model_reset();
      for (int i = 0; i < N; i++) do_cycle();
      #1 check("rf3_after_resweep", rd1, 32'h0);
      check("busy4_after_resweep", 32'(busy2), 32'h0);
      check("ready_after_resweep", 32'(ready), 32'h1);
      do_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
